mem_stack_sequencer: RTL
========================

MEM_STACK_SEQUENCER -- requirements
Module: mem_stack_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning data-memory address width.
REQ-002 The block SHALL have parameter SP_INIT, default 2048, meaning stack-pointer reset value, with an empty stack.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 The block SHALL have ports int_req, rti_req, call_req, ret_req, push_req, pop_req, ld_req, st_req, all input, 1 bit, single-cycle request strobes sampled in IDLE.
REQ-006 The block SHALL have port mr, output, 1, memory read enable.
REQ-007 The block SHALL have port mw, output, 1, memory write enable.
REQ-008 The block SHALL have port sel1, output, 2, write-data select: 00 ALU, 01 PC low, 10 PC high, 11 CCR.
REQ-009 The block SHALL have port sel2, output, 1, address select: 1 stack address, 0 ALU address.
REQ-010 The block SHALL have port sp_addr, output, ADDR_W, stack address for the current access.
REQ-011 The block SHALL have ports pc_lo_we, pc_hi_we, ccr_we, alu_we, all output, 1 bit, strobes to capture popped data in the same cycle.
REQ-012 The block SHALL have port busy, output, 1, sequence in progress, which the pipeline uses as a stall.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse after the last access.
REQ-014 The block SHALL have port stk_fault, output, 1, sticky overflow/underflow flag.

Function
REQ-015 The stack SHALL be full-descending: a push writes mem[SP] then SP<=SP-1; a pop reads mem[SP+1] then SP<=SP+1; sp_addr SHALL equal SP on a push and SP+1 on a pop, modulo 2^ADDR_W.
REQ-016 The states SHALL be IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, POP_CCR, POP_LO, POP_HI, FIN.
REQ-017 In IDLE, requests SHALL be prioritised int > rti > call > ret > push > pop > st > ld; lower simultaneous requests are dropped.
REQ-018 INT SHALL sequence PUSH_HI -> PUSH_LO -> PUSH_CCR -> FIN, with sel1 set to 10, 01, 11 respectively.
REQ-019 CALL SHALL sequence PUSH_HI -> PUSH_LO -> FIN.
REQ-020 RTI SHALL sequence POP_CCR -> POP_LO -> POP_HI -> FIN, asserting ccr_we, pc_lo_we, pc_hi_we in the matching state.
REQ-021 RET SHALL sequence POP_LO -> POP_HI -> FIN.
REQ-022 push_req SHALL perform a single-cycle write from IDLE with sel1=00 and sel2=1.
REQ-023 pop_req SHALL perform a single-cycle read from IDLE with alu_we=1 and sel2=1.
REQ-024 Neither push_req nor pop_req SHALL assert busy or done.
REQ-025 st_req/ld_req SHALL drive mw/mr for one cycle with sel2=0 and sel1=00, leaving SP unchanged.
REQ-026 Every PUSH_* and POP_* state SHALL last exactly one cycle, with sel2=1 and exactly one of mr or mw high.
REQ-027 mr and mw SHALL never be high together.
REQ-028 busy SHALL be high from the cycle after an accepted INT/RTI/CALL/RET through FIN inclusive.
REQ-029 done SHALL be high only in FIN; FIN SHALL return to IDLE.
REQ-030 Requests arriving while busy SHALL be ignored.
REQ-031 Latency SHALL be: CALL/RET 3 cycles, INT/RTI 4 cycles, from request to done.

Reset
REQ-032 Asserting rst SHALL immediately force state=IDLE, SP=SP_INIT, and mr, mw, sel2, busy, done, stk_fault and all *_we to 0, with sel1=00.
REQ-033 A reset mid-sequence SHALL abort the sequence without completing the remaining accesses.
REQ-034 After rst deasserts, the first request SHALL be accepted on the next rising edge.

Configuration
REQ-035 With macro STACK_GUARD_EN defined, a push when SP==0 SHALL set stk_fault and suppress mw and the SP update, and a pop when SP==SP_INIT SHALL set stk_fault and suppress mr, the *_we strobes and the SP update; the sequence SHALL still advance to FIN.
REQ-036 Without STACK_GUARD_EN, SP SHALL wrap modulo 2^ADDR_W and stk_fault SHALL be tied to 0.

Verification
REQ-037 A bench SHALL check: reset, then call_req -> two writes at addr 2048 (sel1=10) and 2047 (sel1=01), done in cycle 3, SP=2046.
REQ-038 A bench SHALL check: call_req followed by ret_req -> reads at 2047 (pc_lo_we) and 2048 (pc_hi_we), SP=2048.
REQ-039 A bench SHALL check: int_req with call_req in the same cycle -> INT sequence only, writes at 2048/2047/2046 with sel1=10/01/11, SP=2045.
REQ-040 A bench SHALL check: rst asserted in PUSH_LO -> mw=0 and busy=0 immediately, SP=2048.
REQ-041 A bench SHALL check: with STACK_GUARD_EN, pop_req right after reset -> stk_fault=1, mr=0, SP=2048; without the macro -> read at addr 2049, SP=2049.
REQ-042 A bench SHALL check: st_req with ld_req -> one write with sel2=0 and no read.

Source files
------------

// File: rtl/mem_stack_sequencer.sv
// mem_stack_sequencer
// Sequences multi-cycle stack traffic for interrupts, returns, calls and
// single-cycle push/pop/load/store accesses to the data memory.
// All control outputs are registered. A request is sampled on the rising edge
// in IDLE. The matching memory access appears in the cycle that follows.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   int_req .. ld_req   single-cycle request strobes, sampled in IDLE
//   mr / mw    memory read / write enable (never both high)
//   sel1       write-data select: 00 ALU, 01 PC low, 10 PC high, 11 CCR
//   sel2       address select: 1 stack address, 0 ALU address
//   sp_addr    stack address for the current access
//   pc_lo_we, pc_hi_we, ccr_we, alu_we   capture strobes for popped data
//   busy       multi-cycle sequence in progress (pipeline stall)
//   done       one-cycle pulse in FIN
//   stk_fault  sticky overflow/underflow flag
//
// Configuration macro: STACK_GUARD_EN
//   When defined, a push at SP==0 or a pop at SP==SP_INIT raises stk_fault
//   and is suppressed. The sequence still runs to FIN.
//   When undefined, SP wraps and stk_fault is tied low.

module mem_stack_sequencer #(
    parameter int ADDR_W  = 12,
    parameter int SP_INIT = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic              rti_req,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic              ld_req,
    input  logic              st_req,
    output logic              mr,
    output logic              mw,
    output logic [1:0]        sel1,
    output logic              sel2,
    output logic [ADDR_W-1:0] sp_addr,
    output logic              pc_lo_we,
    output logic              pc_hi_we,
    output logic              ccr_we,
    output logic              alu_we,
    output logic              busy,
    output logic              done,
    output logic              stk_fault
);

    localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_INIT);

    typedef enum logic [2:0] {
        IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, POP_CCR, POP_LO, POP_HI, FIN
    } state_t;

    typedef enum logic [2:0] {
        ACC_NONE, ACC_PUSH, ACC_POP, ACC_ST, ACC_LD
    } access_t;

    state_t            state;
    state_t            nxt;
    access_t           acc;
    logic [1:0]        nxt_sel1;
    logic [3:0]        nxt_we;
    logic              nxt_is_int;
    logic              is_int;
    logic [ADDR_W-1:0] sp;
    logic              push_ok;
    logic              pop_ok;

`ifdef STACK_GUARD_EN
    logic fault_q;
    assign push_ok   = (sp != '0);
    assign pop_ok    = (sp != SP_RST);
    assign stk_fault = fault_q;
`else
    assign push_ok   = 1'b1;
    assign pop_ok    = 1'b1;
    assign stk_fault = 1'b0;
`endif

    // Decide the next state and the access that state performs.
    // nxt_we is {ccr_we, pc_hi_we, pc_lo_we, alu_we}.
    // INT and CALL share the PUSH_HI/PUSH_LO path. is_int records which one is running.
    always_comb begin
        nxt        = state;
        acc        = ACC_NONE;
        nxt_sel1   = 2'b00;
        nxt_we     = 4'b0000;
        nxt_is_int = is_int;
        case (state)
            IDLE: begin
                if (int_req) begin
                    nxt = PUSH_HI; acc = ACC_PUSH; nxt_sel1 = 2'b10; nxt_is_int = 1'b1;
                end else if (rti_req) begin
                    nxt = POP_CCR; acc = ACC_POP; nxt_we = 4'b1000;
                end else if (call_req) begin
                    nxt = PUSH_HI; acc = ACC_PUSH; nxt_sel1 = 2'b10; nxt_is_int = 1'b0;
                end else if (ret_req) begin
                    nxt = POP_LO; acc = ACC_POP; nxt_we = 4'b0010;
                end else if (push_req) begin
                    acc = ACC_PUSH;
                end else if (pop_req) begin
                    acc = ACC_POP; nxt_we = 4'b0001;
                end else if (st_req) begin
                    acc = ACC_ST;
                end else if (ld_req) begin
                    acc = ACC_LD;
                end
            end
            PUSH_HI: begin
                nxt = PUSH_LO; acc = ACC_PUSH; nxt_sel1 = 2'b01;
            end
            PUSH_LO: begin
                if (is_int) begin
                    nxt = PUSH_CCR; acc = ACC_PUSH; nxt_sel1 = 2'b11;
                end else begin
                    nxt = FIN;
                end
            end
            PUSH_CCR: nxt = FIN;
            POP_CCR: begin
                nxt = POP_LO; acc = ACC_POP; nxt_we = 4'b0010;
            end
            POP_LO: begin
                nxt = POP_HI; acc = ACC_POP; nxt_we = 4'b0100;
            end
            POP_HI:  nxt = FIN;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State, stack pointer and registered outputs.
    // The SP update is committed on the same edge that launches the access.
    // sp_addr therefore holds the pre-update address for the whole access cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            is_int   <= 1'b0;
            sp       <= SP_RST;
            sp_addr  <= '0;
            mr       <= 1'b0;
            mw       <= 1'b0;
            sel1     <= 2'b00;
            sel2     <= 1'b0;
            pc_lo_we <= 1'b0;
            pc_hi_we <= 1'b0;
            ccr_we   <= 1'b0;
            alu_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef STACK_GUARD_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state    <= nxt;
            is_int   <= nxt_is_int;
            busy     <= (nxt != IDLE);
            done     <= (nxt == FIN);
            mr       <= 1'b0;
            mw       <= 1'b0;
            sel1     <= 2'b00;
            sel2     <= 1'b0;
            pc_lo_we <= 1'b0;
            pc_hi_we <= 1'b0;
            ccr_we   <= 1'b0;
            alu_we   <= 1'b0;
            case (acc)
                ACC_PUSH: begin
                    sel2    <= 1'b1;
                    sel1    <= nxt_sel1;
                    sp_addr <= sp;
                    if (push_ok) begin
                        mw <= 1'b1;
                        sp <= sp - 1'b1;
                    end
`ifdef STACK_GUARD_EN
                    else fault_q <= 1'b1;
`endif
                end
                ACC_POP: begin
                    sel2    <= 1'b1;
                    sp_addr <= sp + 1'b1;
                    if (pop_ok) begin
                        mr       <= 1'b1;
                        ccr_we   <= nxt_we[3];
                        pc_hi_we <= nxt_we[2];
                        pc_lo_we <= nxt_we[1];
                        alu_we   <= nxt_we[0];
                        sp       <= sp + 1'b1;
                    end
`ifdef STACK_GUARD_EN
                    else fault_q <= 1'b1;
`endif
                end
                ACC_ST:  mw <= 1'b1;
                ACC_LD:  mr <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
